fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO. Lives entirely in the write clock domain. It keeps the binary write pointer and its Gray copy, and brings the read pointer's Gray code in through a two-flop synchronizer. It converts the synchronized read pointer Gray→binary and derives FULL, ALMOST_FULL and the write-side fill level. Its WR_PTR_GRAY output is the value the read-side synchronizer and Gray-to-binary stage consume.

---
 rtl/fifo_wr_ctrl_pkg.sv | 32 +++
 rtl/fifo_wr_ctrl_if.sv | 32 +++
 rtl/fifo_wr_ctrl_ptr_sync_2ff.sv | 37 +++
 rtl/fifo_wr_ctrl.sv | 91 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_pkg
// Shared constants and pointer-code helpers for the asynchronous FIFO. Both the
// write-side and read-side controllers import this package.
//   FIFO_ADDR_WIDTH : default memory address width
//   FIFO_PTR_WIDTH  : pointer width (one extra bit distinguishes full from empty)
//   FIFO_DEPTH      : number of memory entries
//   bin2gray/gray2bin : 32-bit wide conversions; callers zero-extend narrower
//                       pointers and truncate the result, which is exact because
//                       leading zeros are preserved by both conversions.
// -----------------------------------------------------------------------------
package fifo_wr_ctrl_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = gray[i] ^ bin[i+1];
        end
        return bin;
    endfunction

endpackage : fifo_wr_ctrl_pkg

// File: rtl/fifo_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_if
// Write-side bus of the asynchronous FIFO.
//   master : producer / read-domain side; drives W_INC and RD_PTR_GRAY
//   slave  : fifo_wr_ctrl; drives W_EN, W_ADDR, WR_PTR_GRAY, FULL,
//            ALMOST_FULL and W_LEVEL
// -----------------------------------------------------------------------------
interface fifo_wr_ctrl_if
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
    logic                  W_INC;
    logic [ADDR_WIDTH:0]   RD_PTR_GRAY;
    logic                  W_EN;
    logic [ADDR_WIDTH-1:0] W_ADDR;
    logic [ADDR_WIDTH:0]   WR_PTR_GRAY;
    logic                  FULL;
    logic                  ALMOST_FULL;
    logic [ADDR_WIDTH:0]   W_LEVEL;

    modport master (
        output W_INC, RD_PTR_GRAY,
        input  W_EN, W_ADDR, WR_PTR_GRAY, FULL, ALMOST_FULL, W_LEVEL
    );

    modport slave (
        input  W_INC, RD_PTR_GRAY,
        output W_EN, W_ADDR, WR_PTR_GRAY, FULL, ALMOST_FULL, W_LEVEL
    );

endinterface : fifo_wr_ctrl_if

// File: rtl/fifo_wr_ctrl_ptr_sync_2ff.sv
// -----------------------------------------------------------------------------
// ptr_sync_2ff
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock
// domain. No logic sits between the stages so the first flop has a full cycle
// to resolve metastability.
//   W_CLK    : destination clock (rising edge)
//   W_RST_n  : synchronous active-low reset, clears both stages
//   async_i  : pointer from the other clock domain
//   sync_o   : synchronized pointer (second stage)
// -----------------------------------------------------------------------------
module ptr_sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             W_CLK,
    input  logic             W_RST_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] rq1_q;
    logic [WIDTH-1:0] rq2_q;

    // NOTE: state is updated with non-blocking assignments so both stages
    // sample their inputs before either changes, giving a true two-stage shift.
    always_ff @(posedge W_CLK) begin
        if (!W_RST_n) begin
            rq1_q <= '0;
            rq2_q <= '0;
        end else begin
            rq1_q <= async_i;
            rq2_q <= rq1_q;
        end
    end

    assign sync_o = rq2_q;

endmodule : ptr_sync_2ff

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side pointer and flag controller of the asynchronous FIFO. Everything
// runs on W_CLK. Keeps the binary and Gray write pointers, synchronizes the
// read pointer's Gray code, and produces FULL, ALMOST_FULL and the write-side
// fill level, all registered.
//   W_CLK, W_RST_n     : write clock, synchronous active-low reset
//   wr.W_INC           : producer write request
//   wr.RD_PTR_GRAY     : read pointer (Gray) from the read domain
//   wr.W_EN            : memory write enable (only combinational output)
//   wr.W_ADDR          : memory write address
//   wr.WR_PTR_GRAY     : registered Gray write pointer, to the read domain
//   wr.FULL            : registered full flag
//   wr.ALMOST_FULL     : registered almost-full flag
//   wr.W_LEVEL         : registered occupancy 0..depth as seen from this side
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_MARGIN  = 2
) (
    input  logic           W_CLK,
    input  logic           W_RST_n,
    fifo_wr_ctrl_if.slave  wr
);

    localparam int PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    // Full when the write Gray pointer equals the read Gray pointer with its
    // two top bits inverted: one lap ahead in binary terms.
    localparam logic [PTR_WIDTH-1:0] FULL_FLIP = PTR_WIDTH'(3) << (PTR_WIDTH - 2);
    localparam logic [PTR_WIDTH-1:0] AF_THRESH = PTR_WIDTH'(DEPTH - AF_MARGIN);

    logic [PTR_WIDTH-1:0] wbin_q,  wbin_d;
    logic [PTR_WIDTH-1:0] wgray_q, wgray_d;
    logic [PTR_WIDTH-1:0] level_q, level_d;
    logic                 full_q,  full_d;
    logic                 af_q,    af_d;
    logic                 accept;
    logic [PTR_WIDTH-1:0] rq2;
    logic [PTR_WIDTH-1:0] rbin_sync;

    ptr_sync_2ff #(
        .WIDTH (PTR_WIDTH)
    ) u_rd_ptr_sync (
        .W_CLK   (W_CLK),
        .W_RST_n (W_RST_n),
        .async_i (wr.RD_PTR_GRAY),
        .sync_o  (rq2)
    );

    // NOTE: every signal below is assigned on every pass through the block,
    // so no latch can be inferred.
    always_comb begin
        accept    = wr.W_INC & ~full_q;
        wbin_d    = wbin_q + PTR_WIDTH'(accept);
        wgray_d   = PTR_WIDTH'(bin2gray(32'(wbin_d)));
        rbin_sync = PTR_WIDTH'(gray2bin(32'(rq2)));
        full_d    = (wgray_d == (rq2 ^ FULL_FLIP));
        // Modulo subtraction; the new write and the newly synchronized read
        // pointer land in the same computation so neither update is lost.
        level_d   = wbin_d - rbin_sync;
        af_d      = (level_d >= AF_THRESH);
    end

    always_ff @(posedge W_CLK) begin
        if (!W_RST_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
        end
    end

    assign wr.W_EN        = wr.W_INC & ~full_q;
    assign wr.W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
    assign wr.WR_PTR_GRAY = wgray_q;
    assign wr.FULL        = full_q;
    assign wr.ALMOST_FULL = af_q;
    assign wr.W_LEVEL     = level_q;

endmodule : fifo_wr_ctrl

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=4, AF_MARGIN=2). A counting
// model (total accepted writes, history of read pointers seen at each edge) is
// compared with the DUT on every falling edge; directed phases add literal
// expectations, then a randomized phase with occasional resets follows.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int AW        = 4;
    localparam int PW        = AW + 1;
    localparam int DEPTH     = 1 << AW;
    localparam int MOD       = 1 << PW;
    localparam int AF_MARGIN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_MARGIN  (AF_MARGIN)
    ) dut (
        .W_CLK   (clk),
        .W_RST_n (rst_n),
        .wr      (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code matches.
    function automatic int bin_of_gray(input int g);
        for (int b = 0; b < MOD; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    int m_wtot     = 0;        // writes accepted since last reset
    int m_level    = 0;
    bit m_full     = 1'b0;
    bit m_af       = 1'b0;
    int rd_hist[$] = '{0, 0, 0};  // read pointer (binary) seen at the latest edges, newest first
    bit checking   = 1'b0;
    int rd_count   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wtot  = 0;
            m_level = 0;
            m_full  = 1'b0;
            m_af    = 1'b0;
            rd_hist = '{0, 0, 0};
        end else begin
            if (bus.W_INC && !m_full) m_wtot++;
            rd_hist.push_front(bin_of_gray(int'(bus.RD_PTR_GRAY)));
            void'(rd_hist.pop_back());
            // The read pointer sampled two edges ago is what the flags see now.
            m_level = ((m_wtot % MOD) - rd_hist[2] + MOD) % MOD;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= DEPTH - AF_MARGIN);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("w_en",        32'(bus.W_EN),        32'(bus.W_INC && !m_full));
            check("w_addr",      32'(bus.W_ADDR),      32'(m_wtot % DEPTH));
            check("wr_ptr_gray", 32'(bus.WR_PTR_GRAY), 32'(gray_of(m_wtot % MOD)));
            check("full",        32'(bus.FULL),        32'(m_full));
            check("almost_full", 32'(bus.ALMOST_FULL), 32'(m_af));
            check("w_level",     32'(bus.W_LEVEL),     32'(m_level));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int c);
        rd_count        = c;
        bus.RD_PTR_GRAY = PW'(gray_of(c % MOD));
    endtask

    initial begin
        logic [PW-1:0] prev_gray;
        int            rd_pct;

        bus.W_INC = 1'b1;
        set_rd(0);
        rst_n = 1'b0;

        // Reset held two edges with a write request present.
        tick();
        tick();
        checking = 1'b1;
        check("rst_level", 32'(bus.W_LEVEL),     0);
        check("rst_gray",  32'(bus.WR_PTR_GRAY), 0);
        check("rst_full",  32'(bus.FULL),        0);
        check("rst_af",    32'(bus.ALMOST_FULL), 0);
        check("rst_addr",  32'(bus.W_ADDR),      0);
        bus.W_INC = 1'b0;
        #1;
        check("rst_w_en",  32'(bus.W_EN),        0);

        // Fill with the read pointer parked at 0.
        rst_n     = 1'b1;
        bus.W_INC = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_addr", 32'(bus.W_ADDR), 32'(i));
            tick();
            if (i == 12) check("fill_af_13", 32'(bus.ALMOST_FULL), 0);
            if (i == 13) begin
                check("fill_af_14",    32'(bus.ALMOST_FULL), 1);
                check("fill_level_14", 32'(bus.W_LEVEL),     14);
                check("fill_full_14",  32'(bus.FULL),        0);
            end
        end
        check("fill_full",  32'(bus.FULL),        1);
        check("fill_level", 32'(bus.W_LEVEL),     16);
        check("fill_gray",  32'(bus.WR_PTR_GRAY), 32'h18);

        // Writes while full are dropped.
        for (int i = 0; i < 3; i++) begin
            check("ovf_w_en", 32'(bus.W_EN), 0);
            tick();
            check("ovf_gray",  32'(bus.WR_PTR_GRAY), 32'h18);
            check("ovf_level", 32'(bus.W_LEVEL),     16);
        end

        // Read side frees four entries; visible after the third edge.
        bus.W_INC = 1'b0;
        set_rd(4);
        check("drain_rd_gray", 32'(bus.RD_PTR_GRAY), 32'h06);
        tick();
        check("drain_full_e1",  32'(bus.FULL),    1);
        check("drain_level_e1", 32'(bus.W_LEVEL), 16);
        tick();
        check("drain_full_e2",  32'(bus.FULL),    1);
        check("drain_level_e2", 32'(bus.W_LEVEL), 16);
        tick();
        check("drain_full_e3",  32'(bus.FULL),        0);
        check("drain_level_e3", 32'(bus.W_LEVEL),     12);
        check("drain_af_e3",    32'(bus.ALMOST_FULL), 0);

        // Wrap: 32 writes from reset with reads trailing, never full.
        rst_n = 1'b0;
        set_rd(0);
        tick();
        rst_n     = 1'b1;
        bus.W_INC = 1'b1;
        prev_gray = '0;
        for (int n = 1; n <= 2 * DEPTH; n++) begin
            set_rd((n - 1) > 4 ? n - 5 : 0);
            if (n == DEPTH) check("wrap_addr_15", 32'(bus.W_ADDR), 15);
            tick();
            check("wrap_one_bit", 32'($countones(bus.WR_PTR_GRAY ^ prev_gray)), 1);
            prev_gray = bus.WR_PTR_GRAY;
            if (n == DEPTH)         check("wrap_addr_0",  32'(bus.W_ADDR),      0);
            if (n == 2 * DEPTH - 1) check("wrap_gray_31", 32'(bus.WR_PTR_GRAY), 32'h10);
            if (n == 2 * DEPTH)     check("wrap_gray_32", 32'(bus.WR_PTR_GRAY), 32'h00);
        end

        // Mid-operation reset at level 9.
        rst_n     = 1'b0;
        bus.W_INC = 1'b0;
        set_rd(0);
        tick();
        rst_n     = 1'b1;
        bus.W_INC = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("mid_level_9", 32'(bus.W_LEVEL), 9);
        rst_n = 1'b0;
        tick();
        check("mid_rst_level", 32'(bus.W_LEVEL),     0);
        check("mid_rst_gray",  32'(bus.WR_PTR_GRAY), 0);
        check("mid_rst_full",  32'(bus.FULL),        0);
        check("mid_rst_af",    32'(bus.ALMOST_FULL), 0);

        // Randomized traffic: alternating write-heavy and read-heavy phases.
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rd_pct    = ((cyc / 250) % 2 == 0) ? 25 : 85;
            bus.W_INC = ($urandom_range(0, 99) < (rd_pct == 25 ? 85 : 30));
            if (rd_count < m_wtot && $urandom_range(0, 99) < rd_pct) set_rd(rd_count + 1);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                set_rd(0);
            end else begin
                rst_n = 1'b1;
            end
            tick();
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_wr_ctrl
